store_size_sequencer: RTL and testbench
=======================================

Name: store_size_sequencer

Overview:
- Store-side counterpart of the load-size path in the multicycle MIPS datapath.
- Executes sw/sh/sb as a short memory transaction:
  - sb/sh: read-modify-write of the target word. The new byte or halfword replaces bits [7:0] or [15:0]. The upper bits keep the current memory contents.
  - sw: direct write.
- Sits between the control unit, register B, the ALUOut address and the single-port data memory.
- Owns memory address, write-enable and write data for the duration of a store.

Parameters:
- MEM_READ_LATENCY, 1, cycles from mem_address valid to mem_data_in valid; legal range 1–7.
- DATA_WIDTH, 32, word width; fixed at 32, present for package consistency only.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request from control unit; sampled only in IDLE
- store_size_control  input  2  00 byte, 01 half, 10 word, 11 reserved
- address  input  32  store address (ALUOut)
- store_data_in  input  32  register B value
- mem_data_in  input  32  memory read data
- mem_address  output  32  address to memory
- mem_write  output  1  memory write enable
- mem_data_out  output  32  merged write data
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset (synchronous, active-high) values: state=IDLE, mem_address=0, mem_write=0, mem_data_out=0, busy=0, done=0, internal counter=0.
- All outputs are registered or decoded from the state register only. No combinational path from any input to any output.
- Request capture: at a start edge in IDLE, latch address, store_data_in and store_size_control. The inputs may change afterwards.
- States: IDLE, READ, WRITE, DONE.
  - IDLE, start=1, size byte or half -> READ. Counter loads MEM_READ_LATENCY.
  - IDLE, start=1, size word -> WRITE. No memory read.
  - IDLE, start=1, size 11 -> DONE. No memory access.
  - READ: mem_address=latched address, mem_write=0. Counter decrements each cycle.
  - READ, counter reaches 1 -> WRITE. On that same edge, mem_data_in is captured into the merge register.
  - WRITE: mem_address=latched address, mem_write=1 for exactly one cycle -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Merge rules:
  - byte: {mem[31:8], data[7:0]}
  - half: {mem[31:16], data[15:0]}
  - word: data
  - The low-lane placement matches the load path, which extracts bits [7:0]/[15:0].
- Latency from the start edge to the done-high cycle:
  - byte/half: MEM_READ_LATENCY+2 cycles
  - word: 2 cycles
  - reserved: 1 cycle
- start while busy=1 is ignored; no queuing.
- Reset mid-operation: the next edge forces IDLE. mem_write falls on that edge; a partial merge is never written later.
- mem_data_out holds its last value outside WRITE; it is only meaningful while mem_write=1.

Optional Feature:
- Macro: STORE_ALIGN_CHECK_EN.
- Defined:
  - Adds output misaligned (1 bit, reset 0).
  - At start, half with address[0]!=0, or word with address[1:0]!=0, goes IDLE -> DONE with no memory access.
  - misaligned=1 during that DONE cycle, alongside done.
- Undefined:
  - Port absent.
  - address[1:0] is ignored for all sizes.
  - All requests proceed normally.

Decomposition:
- Package store_pkg contains:
  - size encodings SIZE_BYTE=2'b00, SIZE_HALF=2'b01, SIZE_WORD=2'b10, SIZE_RSVD=2'b11
  - state typedef (IDLE, READ, WRITE, DONE)
  - counter width constant (3 bits)
- The load-size block uses the same size encodings.
- Sub-module store_merge: purely combinational (size, mem word, reg data) -> merged word. It is reusable and separately unit-testable.

Test Plan:
- Byte store, latency 1:
  - Stimulus: mem word 0xAABBCCDD, store_data_in 0x12345678, address 0x40.
  - Response: mem_write pulses once with mem_data_out=0xAABBCC78 at mem_address 0x40. done occurs 3 cycles after start.
- Half store, latency 3:
  - Stimulus: mem word 0xAABBCCDD, store_data_in 0x0000BEEF.
  - Response: write data 0xAABBBEEF. done occurs 5 cycles after start. mem_write=0 throughout READ.
- Word store:
  - Stimulus: store_data_in 0xDEADBEEF.
  - Response: mem_write is high on the first cycle after start with 0xDEADBEEF. No READ cycle. done on the 2nd cycle.
- start re-asserted during READ, and inputs changed after start:
  - Response: the second request is ignored. The write uses the latched address and data. Exactly one mem_write pulse.
- Reset asserted during READ:
  - Response: next cycle busy=0, mem_write=0, all outputs 0. No write ever issued. A new start afterwards completes normally.
- With STORE_ALIGN_CHECK_EN defined, word store at address 0x42:
  - Response: done=1 and misaligned=1 in the cycle after start. mem_write never asserted.
  - The same address with byte size performs a normal write.

Source files
------------

// File: rtl/store_pkg.sv
// Shared definitions for the store-size path: size encodings (shared with the
// load-size block), sequencer state type and counter width.
package store_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    // Wide enough for a read latency of up to 7 cycles
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        DONE  = 2'b11
    } state_e;

    // A halfword must sit on an even address, a word on a multiple of four
    function automatic logic misaligned_req(input logic [1:0] size,
                                            input logic [1:0] addr_lo);
        logic bad;
        bad = 1'b0;
        if (size == SIZE_HALF)
            bad = addr_lo[0];
        else if (size == SIZE_WORD)
            bad = (addr_lo != 2'b00);
        return bad;
    endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational write-data merge: replaces the low byte or low halfword of the
// current memory word with register data, or passes the full word through.
// The low-lane placement mirrors the load path, which extracts [7:0]/[15:0].
module store_merge
    import store_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            size,
    input  logic [DATA_WIDTH-1:0] mem_word,
    input  logic [DATA_WIDTH-1:0] reg_data,
    output logic [DATA_WIDTH-1:0] merged
);

    // Select which lanes come from the register and which keep memory contents
    always_comb begin
        merged = reg_data;
        case (size)
            SIZE_BYTE: merged = {mem_word[DATA_WIDTH-1:8],  reg_data[7:0]};
            SIZE_HALF: merged = {mem_word[DATA_WIDTH-1:16], reg_data[15:0]};
            default:   merged = reg_data;
        endcase
    end

endmodule

// File: rtl/store_size_sequencer.sv
// Store-size sequencer for the multicycle MIPS datapath. Runs sb/sh as a
// read-modify-write of the target word and sw as a single direct write, owning
// the memory address, write enable and write data for the whole transaction.
// Optional build macro: STORE_ALIGN_CHECK_EN adds a misaligned output and
// turns misaligned half/word requests into an immediate DONE with no access.
module store_size_sequencer
    import store_pkg::*;
#(
    parameter int MEM_READ_LATENCY = 1,
    parameter int DATA_WIDTH       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            store_size_control,
    input  logic [31:0]           address,
    input  logic [DATA_WIDTH-1:0] store_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    output logic [31:0]           mem_address,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  busy,
    output logic                  done
`ifdef STORE_ALIGN_CHECK_EN
    ,
    output logic                  misaligned
`endif
);

    localparam logic [CNT_W-1:0] LAT_INIT = MEM_READ_LATENCY[CNT_W-1:0];

    state_e                state;
    logic [CNT_W-1:0]      cnt;
    logic [1:0]            size_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] merged;

    store_merge #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_merge (
        .size    (size_q),
        .mem_word(mem_data_in),
        .reg_data(data_q),
        .merged  (merged)
    );

    // Latch the request operands when a start is accepted; callers may change them afterwards
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            size_q <= store_size_control;
            data_q <= store_data_in;
        end
    end

    // Transaction control: state, read-latency counter and registered memory outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= '0;
            mem_address  <= '0;
            mem_write    <= 1'b0;
            mem_data_out <= '0;
`ifdef STORE_ALIGN_CHECK_EN
            misaligned   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    mem_write <= 1'b0;
`ifdef STORE_ALIGN_CHECK_EN
                    misaligned <= 1'b0;
                    if (start && misaligned_req(store_size_control, address[1:0])) begin
                        state      <= DONE;
                        misaligned <= 1'b1;
                    end else
`endif
                    if (start) begin
                        mem_address <= address;
                        case (store_size_control)
                            SIZE_BYTE, SIZE_HALF: begin
                                state <= READ;
                                cnt   <= LAT_INIT;
                            end
                            SIZE_WORD: begin
                                // Full word needs no read; write data is the register value
                                state        <= WRITE;
                                mem_write    <= 1'b1;
                                mem_data_out <= store_data_in;
                            end
                            default: state <= DONE;
                        endcase
                    end
                end
                READ: begin
                    cnt <= cnt - 1'b1;
                    // Read data is valid on the edge where the counter expires
                    if (cnt == 1) begin
                        state        <= WRITE;
                        mem_write    <= 1'b1;
                        mem_data_out <= merged;
                    end
                end
                WRITE: begin
                    mem_write <= 1'b0;
                    state     <= DONE;
                end
                default: begin
                    state <= IDLE;
`ifdef STORE_ALIGN_CHECK_EN
                    misaligned <= 1'b0;
`endif
                end
            endcase
        end
    end

    // Status decoded from the state register only
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

endmodule

// File: tb/tb_store_size_sequencer.sv
// Directed bench for store_size_sequencer: two instances (read latency 1 and 3)
// share one expected-write queue and one expected-done queue; a monitor pops
// and compares whenever a DUT asserts mem_write or done.
module tb_store_size_sequencer;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_R = 2'b11;

    logic        clk;
    logic        reset      [2];
    logic        start      [2];
    logic [1:0]  size_in    [2];
    logic [31:0] addr_in    [2];
    logic [31:0] data_in    [2];
    logic [31:0] mem_rd     [2];
    logic [31:0] mem_address[2];
    logic        mem_write  [2];
    logic [31:0] mem_dout   [2];
    logic        busy       [2];
    logic        done       [2];
`ifdef STORE_ALIGN_CHECK_EN
    logic        misaligned [2];
`endif

    logic [31:0] mem   [2][64];
    int          rd_age[2];
    logic        mem_init = 1'b1;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    typedef struct { int dut; logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct { int dut; int cyc; logic mis; } dn_t;
    wr_t wq[$];
    dn_t dq[$];

    store_size_sequencer #(.MEM_READ_LATENCY(1)) u0 (
        .clk(clk), .reset(reset[0]), .start(start[0]),
        .store_size_control(size_in[0]), .address(addr_in[0]),
        .store_data_in(data_in[0]), .mem_data_in(mem_rd[0]),
        .mem_address(mem_address[0]), .mem_write(mem_write[0]),
        .mem_data_out(mem_dout[0]), .busy(busy[0]), .done(done[0])
`ifdef STORE_ALIGN_CHECK_EN
        , .misaligned(misaligned[0])
`endif
    );

    store_size_sequencer #(.MEM_READ_LATENCY(3)) u1 (
        .clk(clk), .reset(reset[1]), .start(start[1]),
        .store_size_control(size_in[1]), .address(addr_in[1]),
        .store_data_in(data_in[1]), .mem_data_in(mem_rd[1]),
        .mem_address(mem_address[1]), .mem_write(mem_write[1]),
        .mem_data_out(mem_dout[1]), .busy(busy[1]), .done(done[1])
`ifdef STORE_ALIGN_CHECK_EN
        , .misaligned(misaligned[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: 64 words, read data valid only after the latency has elapsed
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_init) begin
                for (int j = 0; j < 64; j++) mem[k][j] <= 32'hAABBCCDD;
            end else if (mem_write[k]) begin
                mem[k][mem_address[k][7:2]] <= mem_dout[k];
            end
            rd_age[k] <= (busy[k] && !mem_write[k] && !done[k]) ? rd_age[k] + 1 : 0;
        end
    end

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            mem_rd[k] = 32'h5A5A5A5A;
            if (busy[k] && !mem_write[k] && !done[k] &&
                rd_age[k] >= ((k == 0) ? 0 : 2))
                mem_rd[k] = mem[k][mem_address[k][7:2]];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Monitor: every write and every done pulse must match the next expectation
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (mem_write[k]) begin
                if (wq.size() == 0) begin
                    chk($sformatf("unexpected_write_dut%0d", k), {31'd0, mem_write[k]}, 32'd0);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    chk($sformatf("write_dut_id%0d", k), k, e.dut);
                    chk($sformatf("write_addr_dut%0d", k), mem_address[k], e.addr);
                    chk($sformatf("write_data_dut%0d", k), mem_dout[k], e.data);
                end
            end
            if (done[k]) begin
                if (dq.size() == 0) begin
                    chk($sformatf("unexpected_done_dut%0d", k), {31'd0, done[k]}, 32'd0);
                end else begin
                    dn_t d;
                    d = dq.pop_front();
                    chk($sformatf("done_dut_id%0d", k), k, d.dut);
                    chk($sformatf("done_cycle_dut%0d", k), cyc, d.cyc);
`ifdef STORE_ALIGN_CHECK_EN
                    chk($sformatf("misaligned_dut%0d", k), {31'd0, misaligned[k]}, {31'd0, d.mis});
`endif
                end
            end
        end
    end

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        while (busy[i] && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (busy[i]) chk($sformatf("timeout_dut%0d", i), {31'd0, busy[i]}, 32'd0);
        @(negedge clk);
    endtask

    // Issue one request, then scramble the inputs to prove they were latched
    task automatic run(input int i, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] d, input int lat, input bit has_wr,
                       input logic [31:0] wd, input bit mis);
        @(negedge clk);
        if (has_wr) wq.push_back('{i, a, wd});
        dq.push_back('{i, cyc + lat, mis});
        size_in[i] = sz;
        addr_in[i] = a;
        data_in[i] = d;
        start[i]   = 1'b1;
        @(negedge clk);
        start[i]   = 1'b0;
        size_in[i] = ~sz;
        addr_in[i] = ~a;
        data_in[i] = ~d;
        wait_idle(i);
    endtask

    task automatic chk_zero(input int i, input string tag);
        chk({tag, "_busy"},     {31'd0, busy[i]},      32'd0);
        chk({tag, "_mem_write"}, {31'd0, mem_write[i]}, 32'd0);
        chk({tag, "_done"},     {31'd0, done[i]},      32'd0);
        chk({tag, "_mem_addr"}, mem_address[i],        32'd0);
        chk({tag, "_mem_data"}, mem_dout[i],           32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            reset[k] = 1'b1; start[k] = 1'b0; size_in[k] = SZ_B;
            addr_in[k] = 32'd0; data_in[k] = 32'd0;
        end
        repeat (3) @(negedge clk);
        chk_zero(0, "reset_dut0");
        chk_zero(1, "reset_dut1");
        reset[0] = 1'b0;
        reset[1] = 1'b0;
        mem_init = 1'b0;
        @(negedge clk);

        // Latency 1 instance
        run(0, SZ_B, 32'h40, 32'h12345678, 3, 1, 32'hAABBCC78, 0);
        run(0, SZ_W, 32'h48, 32'hDEADBEEF, 2, 1, 32'hDEADBEEF, 0);
        run(0, SZ_R, 32'h4C, 32'h99999999, 1, 0, 32'h0,       0);
        run(0, SZ_H, 32'h50, 32'h11112222, 3, 1, 32'hAABB2222, 0);
        run(0, SZ_B, 32'h40, 32'h000000FF, 3, 1, 32'hAABBCCFF, 0);

        // Latency 3 instance
        run(1, SZ_H, 32'h44, 32'h0000BEEF, 5, 1, 32'hAABBBEEF, 0);
        run(1, SZ_B, 32'h64, 32'h00000033, 5, 1, 32'hAABBCC33, 0);

        // Second start during READ with changed inputs is ignored
        @(negedge clk);
        wq.push_back('{1, 32'h54, 32'hAABBCCA5});
        dq.push_back('{1, cyc + 5, 1'b0});
        size_in[1] = SZ_B; addr_in[1] = 32'h54; data_in[1] = 32'h000000A5; start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0; size_in[1] = SZ_W; addr_in[1] = 32'h58; data_in[1] = 32'hFFFFFFFF;
        @(negedge clk);
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        wait_idle(1);
        repeat (4) @(negedge clk);

        // Reset in the middle of READ aborts without a write
        size_in[1] = SZ_B; addr_in[1] = 32'h5C; data_in[1] = 32'h00000077; start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        reset[1] = 1'b1;
        @(negedge clk);
        chk_zero(1, "midreset_dut1");
        reset[1] = 1'b0;
        repeat (6) @(negedge clk);
        run(1, SZ_W, 32'h60, 32'hCAFEF00D, 2, 1, 32'hCAFEF00D, 0);
        run(1, SZ_H, 32'h5C, 32'h00004321, 5, 1, 32'hAABB4321, 0);

`ifdef STORE_ALIGN_CHECK_EN
        run(0, SZ_W, 32'h42, 32'h0BADF00D, 1, 0, 32'h0,       1);
        run(0, SZ_H, 32'h41, 32'h00001234, 1, 0, 32'h0,       1);
        run(0, SZ_B, 32'h42, 32'h00000011, 3, 1, 32'hAABBCC11, 0);
`else
        run(0, SZ_W, 32'h42, 32'h0BADF00D, 2, 1, 32'h0BADF00D, 0);
        run(0, SZ_B, 32'h42, 32'h00000011, 3, 1, 32'h0BADF011, 0);
`endif

        repeat (5) @(negedge clk);
        chk("pending_writes", wq.size(), 32'd0);
        chk("pending_dones",  dq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
